// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the pipe_chain slice.
//   PIPE_WIDTH - default payload width in bits
//   PIPE_DEPTH - default number of register stages
//   CNT_WIDTH  - width of the performance counters
//   sat_inc()  - saturating increment for the performance counters
package pipe_pkg;

  localparam int unsigned PIPE_WIDTH = 32;
  localparam int unsigned PIPE_DEPTH = 4;
  localparam int unsigned CNT_WIDTH  = 32;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    return (value == '1) ? value : value + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one register stage of the pipe_chain pipeline.
// Ports:
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset (clears valid and data)
//   load_en   - stage is ready: take valid from upstream this edge
//   up_valid  - upstream valid; also qualifies the data load
//   up_data   - upstream payload
//   clear     - force valid to 0 at this edge (data left untouched)
//   valid_q   - registered valid
//   data_q    - registered payload
//   valid_d   - next-state valid, exposed so the parent can keep an
//               occupancy count in step with the valid flops
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             clear,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q,
  output logic             valid_d
);

  // Clear wins over load: an item arriving into a cleared stage is dropped.
  always_comb begin
    valid_d = valid_q;
    if (load_en) begin
      valid_d = up_valid;
    end
    if (clear) begin
      valid_d = 1'b0;
    end
  end

  // Payload only moves when a real item is loaded, so holes do not
  // disturb the data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_en && up_valid) begin
        data_q <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH-stage valid/ready register pipeline with per-stage
// flush, occupancy count and optional stall/bubble counters.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   in_valid/in_ready     - upstream handshake, in_data payload
//   flush[DEPTH-1:0]      - bit i clears stage i at the next edge
//   out_valid/out_ready   - downstream handshake, out_data payload
//   occupancy             - number of valid stages (registered)
//   stall_cnt             - cycles with out_valid=1 and out_ready=0
//   bubble_cnt            - cycles with out_valid=0
// Build option: define PIPE_PERF_CNT_EN to enable the saturating
// stall/bubble counters; otherwise those ports read constant 0.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH,
  parameter int DEPTH = PIPE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [DEPTH-1:0]           flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_WIDTH-1:0]       stall_cnt,
  output logic [CNT_WIDTH-1:0]       bubble_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [OCC_W-1:0] occ_d;

  // A stage can accept when it is empty or when the stage ahead of it
  // accepts; this lets holes collapse while the output is stalled.
  // Flush is deliberately kept out of this chain.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = ~valid_q[i] | rdy[i+1];
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  // Stage i is fed by the input port (i=0) or by stage i-1; the source's
  // own flush bit does not stop its item from moving forward.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_body
      assign up_valid = valid_q[i-1];
      assign up_data  = data_q[i-1];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load_en  (rdy[i]),
      .up_valid (up_valid),
      .up_data  (up_data),
      .clear    (flush[i]),
      .valid_q  (valid_q[i]),
      .data_q   (data_q[i]),
      .valid_d  (valid_d[i])
    );
  end

  // Popcount of the next-state valid vector, so the registered count
  // always matches the valid flops after the same edge.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Performance counters: saturate at all-ones, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (!out_valid) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
    end
  end
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: scoreboard bench for pipe_chain (WIDTH=32, DEPTH=4).
// Accepted input items are queued; each item leaving the pipeline is
// compared against the oldest queued entry.
module tb_pipe_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [DEPTH-1:0] flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       occupancy;
  logic [31:0]      stall_cnt;
  logic [31:0]      bubble_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  pipe_chain #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs from a falling edge, score the handshakes
  // that will complete at the coming rising edge, then wait for the next
  // falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic ordy, input logic [DEPTH-1:0] fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_item", 32'd1, 32'd0);
      end else begin
        checkOutput("out_data", out_data, sb.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(in_data);
    end
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] exp_ov;

    // Reset state
    resetDut();
    #1;
    checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
    checkOutput("rst_bubble_cnt", bubble_cnt, 32'd0);

    // Streaming: 0x11,0x22,0x33 back to back, output 4 cycles after accept
    exp_ov = 8'b0111_0000;
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("stream_out_valid_c%0d", c), 32'(out_valid), 32'(exp_ov[c]));
      applyStimulus(c < 3, 32'h11 * (c + 1), 1'b1, '0);
    end
    checkOutput("stream_drained", 32'(sb.size()), 32'd0);
    checkOutput("stream_stall_cnt", stall_cnt, 32'd0);
    checkOutput("stream_bubble_cnt", bubble_cnt, PERF_ON ? 32'd5 : 32'd0);

    // Fill all stages, then hold the output for 5 cycles
    resetDut();
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("fill_in_ready_c%0d", c), 32'(in_ready), 32'd1);
      applyStimulus(1'b1, 32'hA0 + c, 1'b0, '0);
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall_in_ready_%0d", k), 32'(in_ready), 32'd0);
      checkOutput($sformatf("stall_out_data_%0d", k), out_data, 32'hA0);
      checkOutput($sformatf("stall_occupancy_%0d", k), 32'(occupancy), 32'd4);
      applyStimulus(1'b1, 32'hEE, 1'b0, '0);
    end
    checkOutput("stall_stall_cnt", stall_cnt, PERF_ON ? 32'd5 : 32'd0);
    checkOutput("stall_bubble_cnt", bubble_cnt, PERF_ON ? 32'd4 : 32'd0);
    repeat (6) applyStimulus(1'b0, '0, 1'b1, '0);
    checkOutput("stall_drained", 32'(sb.size()), 32'd0);

    // Bubble collapse: A, -, B, -, - with the output stalled
    resetDut();
    applyStimulus(1'b1, 32'h0A, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 32'h0B, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("collapse_occupancy", 32'(occupancy), 32'd2);
    checkOutput("collapse_out_valid", 32'(out_valid), 32'd1);
    checkOutput("collapse_out_data", out_data, 32'h0A);
    applyStimulus(1'b0, '0, 1'b1, '0);
    checkOutput("collapse_b_next", 32'(out_valid), 32'd1);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, '0);
    checkOutput("collapse_drained", 32'(sb.size()), 32'd0);

    // Flush stage 2: Y (stage 2) moves on, X (stage 1) is dropped
    resetDut();
    applyStimulus(1'b1, 32'h5A, 1'b1, '0);
    applyStimulus(1'b1, 32'hC3, 1'b1, '0);
    applyStimulus(1'b0, '0, 1'b1, '0);
    checkOutput("flush_occ_before", 32'(occupancy), 32'd2);
    sb.delete(1);
    applyStimulus(1'b0, '0, 1'b1, 4'b0100);
    checkOutput("flush_occ_after", 32'(occupancy), 32'd1);
    checkOutput("flush_y_delivered", 32'(out_valid), 32'd1);
    repeat (4) applyStimulus(1'b0, '0, 1'b1, '0);
    checkOutput("flush_out_valid_end", 32'(out_valid), 32'd0);
    checkOutput("flush_drained", 32'(sb.size()), 32'd0);

    // Reset with items in flight and every flush bit set
    resetDut();
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 32'h71 + c, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    rst       = 1'b1;
    flush     = '1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    flush     = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    #1;
    checkOutput("rstflight_occupancy", 32'(occupancy), 32'd0);
    checkOutput("rstflight_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rstflight_out_data", out_data, 32'd0);
    checkOutput("rstflight_stall_cnt", stall_cnt, 32'd0);
    checkOutput("rstflight_bubble_cnt", bubble_cnt, 32'd0);
    checkOutput("rstflight_in_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
